// File: rtl/execute_stage_param.sv
// -----------------------------------------------------------------------------
// execute_stage_param
//
// Execute stage of the pipelined ARM core. Forwards both operands, runs the
// ALU, evaluates the ARM condition against the NZCV register, resolves
// branches and loads the E->M pipeline register. MUL runs over MUL_CYCLES
// cycles. While it runs, StallE holds the upstream stages and bubbles go
// into M.
//
// Ports
//   Clk, reset        rising-edge clock, asynchronous active-high reset
//   ValidE            instruction in E is real (0 = bubble)
//   dataRegAIn/BIn    register-file operands (B is also the store data)
//   extIn             extended immediate
//   ResultW           writeback result for forwarding
//   ForwardAE/BE      00/11 register, 01 ResultW, 10 ALUResultM
//   ALUSrcE           1 = SrcB is extIn
//   ALUControlE       ADD, SUB, AND, ORR, EOR, MUL, MOV, zero
//   CondE, FlagWriteE ARM condition code, NZCV update enable
//   RegWriteE, MemWriteE, MemToRegE, BranchE, PCSrcE, WA3E  decoded controls
//   FlushE            kill the instruction in E
//   ALUResultM, WriteDataM, WA3M, RegWriteM, MemWriteM, MemToRegM, PCSrcM
//                     E->M pipeline register
//   BranchTakenE      combinational branch decision
//   FlagsE            current NZCV {N,Z,C,V}
//   StallE            hold F/D/E while a multiply is in progress
// -----------------------------------------------------------------------------
module execute_stage_param #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  ValidE,
  input  logic [DATA_W-1:0]     dataRegAIn,
  input  logic [DATA_W-1:0]     dataRegBIn,
  input  logic [DATA_W-1:0]     extIn,
  input  logic [DATA_W-1:0]     ResultW,
  input  logic [1:0]            ForwardAE,
  input  logic [1:0]            ForwardBE,
  input  logic                  ALUSrcE,
  input  logic [2:0]            ALUControlE,
  input  logic [3:0]            CondE,
  input  logic                  FlagWriteE,
  input  logic                  RegWriteE,
  input  logic                  MemWriteE,
  input  logic                  MemToRegE,
  input  logic                  BranchE,
  input  logic                  PCSrcE,
  input  logic [REG_ADDR_W-1:0] WA3E,
  input  logic                  FlushE,
  output logic [DATA_W-1:0]     ALUResultM,
  output logic [DATA_W-1:0]     WriteDataM,
  output logic [REG_ADDR_W-1:0] WA3M,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic                  MemToRegM,
  output logic                  PCSrcM,
  output logic                  BranchTakenE,
  output logic [3:0]            FlagsE,
  output logic                  StallE
);

  localparam int MSB = DATA_W - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;

  localparam logic [DATA_W:0] ONE_EXT = {{DATA_W{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Operand forwarding
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] srcA;
  logic [DATA_W-1:0] fwdB;
  logic [DATA_W-1:0] srcB;

  always_comb begin
    case (ForwardAE)
      2'b01:   srcA = ResultW;
      2'b10:   srcA = ALUResultM;
      default: srcA = dataRegAIn;
    endcase
  end

  always_comb begin
    case (ForwardBE)
      2'b01:   fwdB = ResultW;
      2'b10:   fwdB = ALUResultM;
      default: fwdB = dataRegBIn;
    endcase
  end

  assign srcB = ALUSrcE ? extIn : fwdB;

  // ---------------------------------------------------------------------------
  // NZCV register and condition evaluation
  // ---------------------------------------------------------------------------
  logic [3:0] nzcv_reg;
  logic [3:0] nzcv_next;
  logic       flagN;
  logic       flagZ;
  logic       flagC;
  logic       flagV;
  logic       condExE;

  assign {flagN, flagZ, flagC, flagV} = nzcv_reg;

  always_comb begin
    case (CondE)
      4'b0000: condExE = flagZ;                       // EQ
      4'b0001: condExE = ~flagZ;                      // NE
      4'b0010: condExE = flagC;                       // CS/HS
      4'b0011: condExE = ~flagC;                      // CC/LO
      4'b0100: condExE = flagN;                       // MI
      4'b0101: condExE = ~flagN;                      // PL
      4'b0110: condExE = flagV;                       // VS
      4'b0111: condExE = ~flagV;                      // VC
      4'b1000: condExE = flagC & ~flagZ;              // HI
      4'b1001: condExE = ~flagC | flagZ;              // LS
      4'b1010: condExE = (flagN == flagV);            // GE
      4'b1011: condExE = (flagN != flagV);            // LT
      4'b1100: condExE = ~flagZ & (flagN == flagV);   // GT
      4'b1101: condExE = flagZ | (flagN != flagV);    // LE
      4'b1110: condExE = 1'b1;                        // AL
      default: condExE = 1'b0;                        // never
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiply sequencing
  //   mulBusy  : this cycle sends a bubble into M (MUL start or middle cycles)
  //   mulFinal : this cycle completes a MUL and may write M / flags
  // ---------------------------------------------------------------------------
  logic              isMul;
  logic              mulBusy;
  logic              mulFinal;
  logic [DATA_W-1:0] mulOpA;
  logic [DATA_W-1:0] mulOpB;
  logic [DATA_W-1:0] mulLow;

  assign isMul  = (ALUControlE == OP_MUL);
  // Same-width operands: the product keeps only the low DATA_W bits.
  assign mulLow = mulOpA * mulOpB;

  generate
    if (MUL_CYCLES > 1) begin : gMulSeq
      localparam int CNT_W = $clog2(MUL_CYCLES) + 1;

      logic [CNT_W-1:0]  mulCount_reg;
      logic [DATA_W-1:0] mulA_reg;
      logic [DATA_W-1:0] mulB_reg;
      logic              mulStart;

      // A MUL starts only from an idle counter. The final cycle presents the
      // same MUL opcode (upstream is still held), and that must not restart it.
      assign mulStart = ValidE & isMul & ~FlushE & (mulCount_reg == '0);
      assign mulBusy  = mulStart | (mulCount_reg > CNT_W'(1));
      assign mulFinal = (mulCount_reg == CNT_W'(1));
      assign mulOpA   = mulA_reg;
      assign mulOpB   = mulB_reg;

      always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
          mulCount_reg <= '0;
          mulA_reg     <= '0;
          mulB_reg     <= '0;
        end else if (FlushE) begin
          mulCount_reg <= '0;
        end else if (mulStart) begin
          mulCount_reg <= CNT_W'(MUL_CYCLES - 1);
          mulA_reg     <= srcA;
          mulB_reg     <= srcB;
        end else if (mulCount_reg != '0) begin
          mulCount_reg <= mulCount_reg - CNT_W'(1);
        end
      end
    end else begin : gMulComb
      // Single-cycle multiply straight from the forwarded operands.
      assign mulBusy  = 1'b0;
      assign mulFinal = 1'b1;
      assign mulOpA   = srcA;
      assign mulOpB   = srcB;
    end
  endgenerate

  // Flush wins over the stall. Reset also drops it immediately.
  assign StallE = mulBusy & ~FlushE & ~reset;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [DATA_W:0]   addSum;
  logic [DATA_W:0]   subDiff;
  logic              addOvf;
  logic              subOvf;
  logic [DATA_W-1:0] aluResult;
  logic              carryNext;
  logic              ovfNext;

  assign addSum  = {1'b0, srcA} + {1'b0, srcB};
  // Subtract as A + ~B + 1, so the carry out is "no borrow".
  assign subDiff = {1'b0, srcA} + {1'b0, ~srcB} + ONE_EXT;
  assign addOvf  = (srcA[MSB] == srcB[MSB]) & (addSum[MSB]  != srcA[MSB]);
  assign subOvf  = (srcA[MSB] != srcB[MSB]) & (subDiff[MSB] != srcA[MSB]);

  always_comb begin
    aluResult = '0;
    carryNext = flagC;
    ovfNext   = flagV;
    case (ALUControlE)
      OP_ADD: begin
        aluResult = addSum[MSB:0];
        carryNext = addSum[DATA_W];
        ovfNext   = addOvf;
      end
      OP_SUB: begin
        aluResult = subDiff[MSB:0];
        carryNext = subDiff[DATA_W];
        ovfNext   = subOvf;
      end
      OP_AND:  aluResult = srcA & srcB;
      OP_ORR:  aluResult = srcA | srcB;
      OP_EOR:  aluResult = srcA ^ srcB;
      OP_MUL:  aluResult = mulLow;
      OP_MOV:  aluResult = srcB;
      default: aluResult = '0;
    endcase
  end

  assign nzcv_next = {aluResult[MSB], (aluResult == '0), carryNext, ovfNext};

  // ---------------------------------------------------------------------------
  // Gating, branch resolution and flag update
  // ---------------------------------------------------------------------------
  logic writeGate;
  logic opDone;
  logic loadBubble;

  assign writeGate    = ValidE & condExE & ~FlushE;
  assign opDone       = ~isMul | mulFinal;
  assign loadBubble   = ~ValidE | FlushE | mulBusy;
  assign BranchTakenE = ValidE & BranchE & condExE & ~FlushE;
  assign FlagsE       = nzcv_reg;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      nzcv_reg <= 4'b0000;
    end else if (FlagWriteE & writeGate & opDone) begin
      nzcv_reg <= nzcv_next;
    end
  end

  // ---------------------------------------------------------------------------
  // E->M pipeline register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      WA3M       <= '0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemToRegM  <= 1'b0;
      PCSrcM     <= 1'b0;
    end else if (loadBubble) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      WA3M       <= '0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemToRegM  <= 1'b0;
      PCSrcM     <= 1'b0;
    end else begin
      ALUResultM <= aluResult;
      WriteDataM <= fwdB;
      WA3M       <= WA3E;
      RegWriteM  <= RegWriteE & writeGate;
      MemWriteM  <= MemWriteE & writeGate;
      // Not a write: only validity and flush matter, not the condition.
      MemToRegM  <= MemToRegE;
      PCSrcM     <= PCSrcE & writeGate;
    end
  end

endmodule

// File: tb/tb_execute_stage_param.sv
module tb_execute_stage_param;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int MC = 4;

  logic          Clk = 1'b0;
  logic          reset;
  logic          ValidE;
  logic [DW-1:0] dataRegAIn, dataRegBIn, extIn, ResultW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          ALUSrcE;
  logic [2:0]    ALUControlE;
  logic [3:0]    CondE;
  logic          FlagWriteE, RegWriteE, MemWriteE, MemToRegE, BranchE, PCSrcE;
  logic [AW-1:0] WA3E;
  logic          FlushE;
  logic [DW-1:0] ALUResultM, WriteDataM;
  logic [AW-1:0] WA3M;
  logic          RegWriteM, MemWriteM, MemToRegM, PCSrcM;
  logic          BranchTakenE;
  logic [3:0]    FlagsE;
  logic          StallE;

  execute_stage_param #(.DATA_W(DW), .REG_ADDR_W(AW), .MUL_CYCLES(MC)) dut (
    .Clk(Clk), .reset(reset), .ValidE(ValidE),
    .dataRegAIn(dataRegAIn), .dataRegBIn(dataRegBIn), .extIn(extIn), .ResultW(ResultW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .CondE(CondE), .FlagWriteE(FlagWriteE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemToRegE(MemToRegE),
    .BranchE(BranchE), .PCSrcE(PCSrcE), .WA3E(WA3E), .FlushE(FlushE),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemToRegM(MemToRegM),
    .PCSrcM(PCSrcM), .BranchTakenE(BranchTakenE), .FlagsE(FlagsE), .StallE(StallE)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: what M and NZCV should hold.
  logic [DW-1:0] mAlu, mWd;
  logic [AW-1:0] mWa;
  logic          mRw, mMw, mMtr, mPcs;
  logic [3:0]    mFlags;

  function automatic logic condPass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    mAlu = '0; mWd = '0; mWa = '0;
    mRw = 0; mMw = 0; mMtr = 0; mPcs = 0; mFlags = 4'b0000;
  endtask

  // Computes the expected M load from the present inputs, advances one clock
  // and commits the expectation. mulBubble marks a MUL start/middle cycle;
  // la/lb are the operands a MUL captured on its first cycle.
  task automatic tick_model(input bit mulBubble, input logic [DW-1:0] la, input logic [DW-1:0] lb);
    logic [DW-1:0] a, fb, b, r;
    logic          c, v, g, bub;
    longint        us, ss;
    a  = (ForwardAE == 2'b01) ? ResultW : (ForwardAE == 2'b10) ? mAlu : dataRegAIn;
    fb = (ForwardBE == 2'b01) ? ResultW : (ForwardBE == 2'b10) ? mAlu : dataRegBIn;
    b  = ALUSrcE ? extIn : fb;
    c  = mFlags[1];
    v  = mFlags[0];
    case (ALUControlE)
      3'd0: begin
        us = longint'({32'b0, a}) + longint'({32'b0, b});
        ss = longint'($signed(a)) + longint'($signed(b));
        r  = us[31:0];
        c  = (us >> 32) != 0;
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      3'd1: begin
        ss = longint'($signed(a)) - longint'($signed(b));
        r  = a - b;
        c  = (a >= b);
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = la * lb;
      3'd6: r = b;
      default: r = '0;
    endcase
    g   = ValidE && condPass(CondE, mFlags) && !FlushE;
    bub = !ValidE || FlushE || mulBubble;
    @(posedge Clk);
    #1;
    if (FlagWriteE && g && !mulBubble) mFlags = {r[31], (r == 0), c, v};
    if (bub) begin
      mAlu = '0; mWd = '0; mWa = '0; mRw = 0; mMw = 0; mMtr = 0; mPcs = 0;
    end else begin
      mAlu = r; mWd = fb; mWa = WA3E;
      mRw = RegWriteE && g; mMw = MemWriteE && g; mPcs = PCSrcE && g; mMtr = MemToRegE;
    end
  endtask

  task automatic set_idle();
    ValidE = 0; dataRegAIn = 0; dataRegBIn = 0; extIn = 0; ResultW = 0;
    ForwardAE = 0; ForwardBE = 0; ALUSrcE = 0; ALUControlE = 0; CondE = 4'hE;
    FlagWriteE = 0; RegWriteE = 0; MemWriteE = 0; MemToRegE = 0; BranchE = 0;
    PCSrcE = 0; WA3E = 0; FlushE = 0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 0;
    #1 reset = 1;
    #1;
    total++;
    if ({ALUResultM, WriteDataM, WA3M, RegWriteM, MemWriteM, MemToRegM, PCSrcM} !== '0) begin
      bad++; $display("FAIL reset_m: got res=%h wd=%h wa=%h ctl=%b%b%b%b want all 0",
                      ALUResultM, WriteDataM, WA3M, RegWriteM, MemWriteM, MemToRegM, PCSrcM);
    end
    total++;
    if ({FlagsE, StallE} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got nzcv=%b stall=%b want 0000 0", FlagsE, StallE);
    end
    @(negedge Clk);
    reset = 0;
    model_reset();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_add();
    set_idle();
    ValidE = 1; dataRegAIn = 5; dataRegBIn = 2; RegWriteE = 1; WA3E = 4'd3;
    ALUSrcE = 1; extIn = 1;
    tick_model(0, 0, 0);
    total++;
    if ({ALUResultM, RegWriteM, WA3M} !== {32'd6, 1'b1, 4'd3}) begin
      bad++; $display("FAIL add_imm: got res=%0d rw=%b wa=%0d want 6 1 3", ALUResultM, RegWriteM, WA3M);
    end
    ALUSrcE = 0;
    tick_model(0, 0, 0);
    total++;
    if ({ALUResultM, RegWriteM, WriteDataM} !== {32'd7, 1'b1, 32'd2}) begin
      bad++; $display("FAIL add_reg: got res=%0d rw=%b wd=%0d want 7 1 2", ALUResultM, RegWriteM, WriteDataM);
    end
  endtask

  task automatic test_forward();
    set_idle();
    ValidE = 1; RegWriteE = 1; ALUControlE = 3'd1;
    ForwardAE = 2'b01; ResultW = 9; ForwardBE = 2'b10; dataRegAIn = 100; dataRegBIn = 100;
    tick_model(0, 0, 0);
    total++;
    if (ALUResultM !== 32'd2) begin
      bad++; $display("FAIL fwd_sub: got res=%0d want 2", ALUResultM);
    end
    ForwardAE = 0; ForwardBE = 0; dataRegAIn = 2; dataRegBIn = 7; FlagWriteE = 1;
    tick_model(0, 0, 0);
    total++;
    if ({ALUResultM, FlagsE} !== {32'hFFFF_FFFB, 4'b1000}) begin
      bad++; $display("FAIL sub_neg: got res=%h nzcv=%b want fffffffb 1000", ALUResultM, FlagsE);
    end
  endtask

  task automatic test_cond();
    set_idle();
    ValidE = 1; ALUControlE = 3'd1; dataRegAIn = 3; dataRegBIn = 3; FlagWriteE = 1;
    tick_model(0, 0, 0);
    total++;
    if (FlagsE !== 4'b0110) begin
      bad++; $display("FAIL sub_eq_flags: got nzcv=%b want 0110", FlagsE);
    end
    set_idle();
    ValidE = 1; BranchE = 1; PCSrcE = 1; CondE = 4'b0000;
    #1;
    total++;
    if (BranchTakenE !== 1'b1) begin
      bad++; $display("FAIL br_eq: got taken=%b want 1", BranchTakenE);
    end
    tick_model(0, 0, 0);
    total++;
    if (PCSrcM !== 1'b1) begin
      bad++; $display("FAIL br_eq_pcsrc: got pcsrc=%b want 1", PCSrcM);
    end
    CondE = 4'b0001; RegWriteE = 1; MemWriteE = 1;
    #1;
    total++;
    if (BranchTakenE !== 1'b0) begin
      bad++; $display("FAIL br_ne: got taken=%b want 0", BranchTakenE);
    end
    tick_model(0, 0, 0);
    total++;
    if ({RegWriteM, MemWriteM, PCSrcM} !== 3'b000) begin
      bad++; $display("FAIL ne_gate: got rw=%b mw=%b pcs=%b want 0 0 0", RegWriteM, MemWriteM, PCSrcM);
    end
  endtask

  task automatic test_flags();
    set_idle();
    ValidE = 1; FlagWriteE = 1; dataRegAIn = 32'h7FFF_FFFF; dataRegBIn = 1;
    tick_model(0, 0, 0);
    total++;
    if ({ALUResultM, FlagsE} !== {32'h8000_0000, 4'b1001}) begin
      bad++; $display("FAIL add_ovf: got res=%h nzcv=%b want 80000000 1001", ALUResultM, FlagsE);
    end
    ALUControlE = 3'd2; dataRegAIn = 32'hF0; dataRegBIn = 32'h0F;
    tick_model(0, 0, 0);
    total++;
    if (FlagsE !== 4'b0101) begin
      bad++; $display("FAIL and_keep_cv: got nzcv=%b want 0101", FlagsE);
    end
  endtask

  task automatic test_mul();
    int stallCnt;
    set_idle();
    ValidE = 1; ALUControlE = 3'd5; dataRegAIn = 6; dataRegBIn = 7; RegWriteE = 1; WA3E = 4'd5;
    stallCnt = 0;
    for (int i = 0; i < MC + 2; i++) begin
      #1;
      if (!StallE) break;
      stallCnt++;
      tick_model(1, 6, 7);
      total++;
      if (RegWriteM !== 1'b0) begin
        bad++; $display("FAIL mul_bubble: got rw=%b want 0 (stall cycle %0d)", RegWriteM, stallCnt);
      end
      dataRegAIn = $urandom; dataRegBIn = $urandom;
    end
    total++;
    if (stallCnt != MC - 1) begin
      bad++; $display("FAIL mul_stall_len: got %0d want %0d", stallCnt, MC - 1);
    end
    tick_model(0, 6, 7);
    total++;
    if ({ALUResultM, RegWriteM, WA3M} !== {32'd42, 1'b1, 4'd5}) begin
      bad++; $display("FAIL mul_result: got res=%0d rw=%b wa=%0d want 42 1 5", ALUResultM, RegWriteM, WA3M);
    end
    $display("txn mul 6*7 stalls=%0d res=%0d", stallCnt, ALUResultM);
  endtask

  task automatic test_back_to_back();
    set_idle();
    ValidE = 1; ALUControlE = 3'd0; ForwardAE = 2'b10; dataRegBIn = 8; RegWriteE = 1;
    #1;
    total++;
    if (StallE !== 1'b0) begin
      bad++; $display("FAIL b2b_stall: got stall=%b want 0", StallE);
    end
    tick_model(0, 0, 0);
    total++;
    if ({ALUResultM, RegWriteM} !== {32'd50, 1'b1}) begin
      bad++; $display("FAIL b2b_fwd: got res=%0d rw=%b want 50 1", ALUResultM, RegWriteM);
    end
  endtask

  task automatic test_flush();
    logic [3:0] saved;
    set_idle();
    saved = mFlags;
    ValidE = 1; ALUControlE = 3'd5; dataRegAIn = 3; dataRegBIn = 4; RegWriteE = 1; FlagWriteE = 1;
    #1;
    total++;
    if (StallE !== 1'b1) begin
      bad++; $display("FAIL flush_start: got stall=%b want 1", StallE);
    end
    tick_model(1, 3, 4);
    FlushE = 1;
    #1;
    total++;
    if (StallE !== 1'b0) begin
      bad++; $display("FAIL flush_wins: got stall=%b want 0", StallE);
    end
    tick_model(1, 3, 4);
    FlushE = 0; ValidE = 0;
    #1;
    total++;
    if (StallE !== 1'b0) begin
      bad++; $display("FAIL flush_abort: got stall=%b want 0", StallE);
    end
    for (int i = 0; i < MC; i++) begin
      tick_model(0, 3, 4);
      total++;
      if ({RegWriteM, ALUResultM, FlagsE, StallE} !== {1'b0, 32'd0, saved, 1'b0}) begin
        bad++; $display("FAIL flush_quiet: got rw=%b res=%h nzcv=%b stall=%b want 0 0 %b 0",
                        RegWriteM, ALUResultM, FlagsE, StallE, saved);
      end
    end
    // Asynchronous reset in the middle of a multiply.
    ValidE = 1; dataRegAIn = 9; dataRegBIn = 9;
    tick_model(1, 9, 9);
    tick_model(1, 9, 9);
    #2 reset = 1;
    #1;
    total++;
    if ({ALUResultM, WA3M, RegWriteM, MemWriteM, MemToRegM, PCSrcM, FlagsE, StallE} !== '0) begin
      bad++; $display("FAIL reset_mid_mul: got res=%h rw=%b nzcv=%b stall=%b want all 0",
                      ALUResultM, RegWriteM, FlagsE, StallE);
    end
    ValidE = 0;
    #1 reset = 0;
    model_reset();
    @(posedge Clk);
    #1;
    total++;
    if ({StallE, RegWriteM} !== 2'b00) begin
      bad++; $display("FAIL after_reset: got stall=%b rw=%b want 0 0", StallE, RegWriteM);
    end
  endtask

  task automatic test_random();
    int  sel;
    logic expBr;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 6);
      ALUControlE = (sel >= 5) ? 3'(sel + 1) : 3'(sel);
      ValidE      = ($urandom_range(0, 7) != 0);
      FlushE      = ($urandom_range(0, 9) == 0);
      dataRegAIn  = $urandom;
      dataRegBIn  = ($urandom_range(0, 3) == 0) ? dataRegAIn : $urandom;
      extIn       = $urandom;
      ResultW     = $urandom;
      ForwardAE   = 2'($urandom_range(0, 3));
      ForwardBE   = 2'($urandom_range(0, 3));
      ALUSrcE     = 1'($urandom_range(0, 1));
      CondE       = 4'($urandom_range(0, 15));
      FlagWriteE  = 1'($urandom_range(0, 1));
      RegWriteE   = 1'($urandom_range(0, 1));
      MemWriteE   = 1'($urandom_range(0, 1));
      MemToRegE   = 1'($urandom_range(0, 1));
      BranchE     = 1'($urandom_range(0, 1));
      PCSrcE      = 1'($urandom_range(0, 1));
      WA3E        = 4'($urandom_range(0, 15));
      #1;
      expBr = ValidE && BranchE && condPass(CondE, mFlags) && !FlushE;
      total++;
      if ({BranchTakenE, StallE} !== {expBr, 1'b0}) begin
        bad++; $display("FAIL rnd_branch %0d: got taken=%b stall=%b want %b 0", i, BranchTakenE, StallE, expBr);
      end
      tick_model(0, 0, 0);
      total++;
      if ({ALUResultM, WriteDataM, WA3M, RegWriteM, MemWriteM, MemToRegM, PCSrcM, FlagsE} !==
          {mAlu, mWd, mWa, mRw, mMw, mMtr, mPcs, mFlags}) begin
        bad++; $display("FAIL rnd_m %0d: got res=%h wd=%h wa=%h ctl=%b%b%b%b nzcv=%b want %h %h %h %b%b%b%b %b",
                        i, ALUResultM, WriteDataM, WA3M, RegWriteM, MemWriteM, MemToRegM, PCSrcM, FlagsE,
                        mAlu, mWd, mWa, mRw, mMw, mMtr, mPcs, mFlags);
      end
      $display("txn rnd %0d op=%0d v=%b f=%b cond=%h res=%h nzcv=%b", i, ALUControlE, ValidE, FlushE,
               CondE, ALUResultM, FlagsE);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_cond();
    test_flags();
    test_mul();
    test_back_to_back();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
